// File: rtl/rf_wbck_ctrl.sv
// -----------------------------------------------------------------------------
// rf_wbck_ctrl
//
// Write-back controller and outstanding-instruction scoreboard for the
// 32-entry integer regfile.
//
// - Owns the regfile's single write port. The long-pipe path (LSU/MULDIV)
//   always wins over the single-cycle ALU path.
// - Keeps an in-order table of outstanding long-pipe instructions (OITF).
//   Dispatch uses it to detect RAW and WAW hazards against destinations that
//   are still in flight.
//
// Compile-time option:
//   RF_WBCK_WAW_CHK_EN  defined   : dep_waw_o compares rd against the OITF.
//                       undefined : dep_waw_o is tied to 0 and the rd
//                                   comparators are not built.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   disp_alc_*          allocate an OITF entry for a long-pipe op;
//                       disp_alc_ptr_o is the entry's tag
//   disp_rs1/rs2/rd_*   operand indices checked for hazards
//   dep_raw_o           a source matches an in-flight destination
//   dep_waw_o           the destination matches an in-flight destination
//   oitf_empty_o        no long-pipe ops outstanding
//   alu_wbck_*          ALU write-back request/response
//   lng_wbck_*          long-pipe completion for the head entry
//   wbck_dest_*         regfile write port
// -----------------------------------------------------------------------------
module rf_wbck_ctrl #(
   parameter int unsigned OITF_DEPTH  = 2,
   parameter int unsigned RFIDX_WIDTH = 5,
   parameter int unsigned XLEN        = 32,
   localparam int unsigned PtrW       = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,

   // OITF allocation from dispatch
   input  logic                   disp_alc_vld_i,
   output logic                   disp_alc_rdy_o,
   input  logic                   disp_alc_rdwen_i,
   input  logic [RFIDX_WIDTH-1:0] disp_alc_rdidx_i,
   output logic [PtrW-1:0]        disp_alc_ptr_o,

   // Hazard check
   input  logic                   disp_rs1_en_i,
   input  logic                   disp_rs2_en_i,
   input  logic                   disp_rd_en_i,
   input  logic [RFIDX_WIDTH-1:0] disp_rs1_idx_i,
   input  logic [RFIDX_WIDTH-1:0] disp_rs2_idx_i,
   input  logic [RFIDX_WIDTH-1:0] disp_rd_idx_i,
   output logic                   dep_raw_o,
   output logic                   dep_waw_o,
   output logic                   oitf_empty_o,

   // ALU write-back
   input  logic                   alu_wbck_vld_i,
   output logic                   alu_wbck_rdy_o,
   input  logic [RFIDX_WIDTH-1:0] alu_wbck_idx_i,
   input  logic [XLEN-1:0]        alu_wbck_data_i,

   // Long-pipe write-back
   input  logic                   lng_wbck_vld_i,
   output logic                   lng_wbck_rdy_o,
   input  logic [PtrW-1:0]        lng_wbck_itag_i,
   input  logic [XLEN-1:0]        lng_wbck_data_i,

   // Regfile write port
   output logic                   wbck_dest_wen_o,
   output logic [RFIDX_WIDTH-1:0] wbck_dest_idx_o,
   output logic [XLEN-1:0]        wbck_dest_data_o
);

   // ---------------------------------------------------------------------------
   // OITF storage and pointers
   // ---------------------------------------------------------------------------
   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // without a separate occupancy counter.
   logic [PtrW:0]            wptr_q, wptr_d;
   logic [PtrW:0]            rptr_q, rptr_d;

   logic [OITF_DEPTH-1:0]    vld_q, vld_d;
   logic [OITF_DEPTH-1:0]    rdwen_q, rdwen_d;
   logic [RFIDX_WIDTH-1:0]   rdidx_q [OITF_DEPTH];
   logic [RFIDX_WIDTH-1:0]   rdidx_d [OITF_DEPTH];

   logic [PtrW-1:0]          wr_idx;
   logic [PtrW-1:0]          rd_idx;
   logic                     empty;
   logic                     full;
   logic                     alc_fire;
   logic                     ret_fire;

   localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

   assign wr_idx = wptr_q[PtrW-1:0];
   assign rd_idx = rptr_q[PtrW-1:0];

   assign empty  = (wptr_q == rptr_q);
   assign full   = (wr_idx == rd_idx) && (wptr_q[PtrW] != rptr_q[PtrW]);

   // Allocation looks only at the current fill level: a retire in the same
   // cycle does not free the slot until the next cycle.
   assign alc_fire = disp_alc_vld_i & ~full;
   assign ret_fire = lng_wbck_vld_i & ~empty;

   assign disp_alc_rdy_o = ~full;
   assign disp_alc_ptr_o = wr_idx;
   assign oitf_empty_o   = empty;
   assign lng_wbck_rdy_o = ~empty;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      vld_d   = vld_q;
      rdwen_d = rdwen_q;
      rdidx_d = rdidx_q;

      // Retire and allocate never address the same slot: that would need the
      // table to be simultaneously full (no allocate) and empty (no retire).
      if (ret_fire) begin
         vld_d[rd_idx] = 1'b0;
         rptr_d        = rptr_q + PtrOne;
      end

      if (alc_fire) begin
         vld_d[wr_idx]   = 1'b1;
         rdwen_d[wr_idx] = disp_alc_rdwen_i;
         rdidx_d[wr_idx] = disp_alc_rdidx_i;
         wptr_d          = wptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         vld_q   <= '0;
         rdwen_q <= '0;
         for (int i = 0; i < OITF_DEPTH; i++) begin
            rdidx_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         vld_q   <= vld_d;
         rdwen_q <= rdwen_d;
         for (int i = 0; i < OITF_DEPTH; i++) begin
            rdidx_q[i] <= rdidx_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Hazard check
   // ---------------------------------------------------------------------------
   // An entry can cause a hazard only if it is valid, writes rd, and rd is not
   // x0 (writes to x0 are discarded, so nothing ever waits on them).
   logic [OITF_DEPTH-1:0] ent_live;

   for (genvar g = 0; g < OITF_DEPTH; g++) begin : g_live
      assign ent_live[g] = vld_q[g] & rdwen_q[g] & (rdidx_q[g] != '0);
   end

   logic raw_hit;

   always_comb begin
      raw_hit = 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         if (ent_live[i]) begin
            if (disp_rs1_en_i && (disp_rs1_idx_i == rdidx_q[i])) raw_hit = 1'b1;
            if (disp_rs2_en_i && (disp_rs2_idx_i == rdidx_q[i])) raw_hit = 1'b1;
         end
      end
   end

   assign dep_raw_o = raw_hit;

`ifdef RF_WBCK_WAW_CHK_EN
   logic waw_hit;

   always_comb begin
      waw_hit = 1'b0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
         if (ent_live[i] && disp_rd_en_i && (disp_rd_idx_i == rdidx_q[i])) begin
            waw_hit = 1'b1;
         end
      end
   end

   assign dep_waw_o = waw_hit;
`else
   // Without the WAW check dispatch must serialise same-rd long-pipe ops.
   logic unused_rd_chk;

   assign dep_waw_o     = 1'b0;
   assign unused_rd_chk = disp_rd_en_i ^ (^disp_rd_idx_i);
`endif

   // ---------------------------------------------------------------------------
   // Write-back arbitration: long-pipe over ALU
   // ---------------------------------------------------------------------------
   // The completing op is always the head; the tag only exists for the
   // producer's benefit and is not cross-checked here.
   logic unused_itag;

   assign unused_itag = ^lng_wbck_itag_i;

   logic lng_sel;

   assign lng_sel        = lng_wbck_vld_i & ~empty;
   assign alu_wbck_rdy_o = ~lng_sel;

   always_comb begin
      if (lng_sel) begin
         wbck_dest_wen_o  = rdwen_q[rd_idx] & (rdidx_q[rd_idx] != '0);
         wbck_dest_idx_o  = rdidx_q[rd_idx];
         wbck_dest_data_o = lng_wbck_data_i;
      end else begin
         // x0 writes still handshake; only the regfile enable is suppressed.
         wbck_dest_wen_o  = alu_wbck_vld_i & (alu_wbck_idx_i != '0);
         wbck_dest_idx_o  = alu_wbck_idx_i;
         wbck_dest_data_o = alu_wbck_data_i;
      end
   end

endmodule

// File: tb/tb_rf_wbck_ctrl.sv
module tb_rf_wbck_ctrl;

   logic        clk;
   logic        rst_n;
   logic        disp_alc_vld;
   logic        disp_alc_rdy;
   logic        disp_alc_rdwen;
   logic [4:0]  disp_alc_rdidx;
   logic        disp_alc_ptr;
   logic        disp_rs1_en, disp_rs2_en, disp_rd_en;
   logic [4:0]  disp_rs1_idx, disp_rs2_idx, disp_rd_idx;
   logic        dep_raw, dep_waw, oitf_empty;
   logic        alu_wbck_vld, alu_wbck_rdy;
   logic [4:0]  alu_wbck_idx;
   logic [31:0] alu_wbck_data;
   logic        lng_wbck_vld, lng_wbck_rdy;
   logic        lng_wbck_itag;
   logic [31:0] lng_wbck_data;
   logic        wbck_dest_wen;
   logic [4:0]  wbck_dest_idx;
   logic [31:0] wbck_dest_data;

   int n_cmp = 0;
   int n_err = 0;

`ifdef RF_WBCK_WAW_CHK_EN
   localparam logic WawExp = 1'b1;
`else
   localparam logic WawExp = 1'b0;
`endif

   rf_wbck_ctrl #(
      .OITF_DEPTH  (2),
      .RFIDX_WIDTH (5),
      .XLEN        (32)
   ) u_dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .disp_alc_vld_i   (disp_alc_vld),
      .disp_alc_rdy_o   (disp_alc_rdy),
      .disp_alc_rdwen_i (disp_alc_rdwen),
      .disp_alc_rdidx_i (disp_alc_rdidx),
      .disp_alc_ptr_o   (disp_alc_ptr),
      .disp_rs1_en_i    (disp_rs1_en),
      .disp_rs2_en_i    (disp_rs2_en),
      .disp_rd_en_i     (disp_rd_en),
      .disp_rs1_idx_i   (disp_rs1_idx),
      .disp_rs2_idx_i   (disp_rs2_idx),
      .disp_rd_idx_i    (disp_rd_idx),
      .dep_raw_o        (dep_raw),
      .dep_waw_o        (dep_waw),
      .oitf_empty_o     (oitf_empty),
      .alu_wbck_vld_i   (alu_wbck_vld),
      .alu_wbck_rdy_o   (alu_wbck_rdy),
      .alu_wbck_idx_i   (alu_wbck_idx),
      .alu_wbck_data_i  (alu_wbck_data),
      .lng_wbck_vld_i   (lng_wbck_vld),
      .lng_wbck_rdy_o   (lng_wbck_rdy),
      .lng_wbck_itag_i  (lng_wbck_itag),
      .lng_wbck_data_i  (lng_wbck_data),
      .wbck_dest_wen_o  (wbck_dest_wen),
      .wbck_dest_idx_o  (wbck_dest_idx),
      .wbck_dest_data_o (wbck_dest_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #2;
   endtask

   task automatic idle();
      disp_alc_vld   = 1'b0;
      disp_alc_rdwen = 1'b0;
      disp_alc_rdidx = '0;
      disp_rs1_en    = 1'b0;
      disp_rs2_en    = 1'b0;
      disp_rd_en     = 1'b0;
      disp_rs1_idx   = '0;
      disp_rs2_idx   = '0;
      disp_rd_idx    = '0;
      alu_wbck_vld   = 1'b0;
      alu_wbck_idx   = '0;
      alu_wbck_data  = '0;
      lng_wbck_vld   = 1'b0;
      lng_wbck_itag  = 1'b0;
      lng_wbck_data  = '0;
   endtask

   task automatic probe_raw(input string tag, input logic [4:0] idx, input logic exp);
      disp_rs1_en  = 1'b1;
      disp_rs1_idx = idx;
      settle();
      check_val(tag, {31'b0, dep_raw}, {31'b0, exp});
      disp_rs1_en  = 1'b0;
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      settle();

      // Reset state
      check_val("rst_empty",   {31'b0, oitf_empty},   32'd1);
      check_val("rst_alc_rdy", {31'b0, disp_alc_rdy}, 32'd1);
      check_val("rst_lng_rdy", {31'b0, lng_wbck_rdy}, 32'd0);
      check_val("rst_alc_ptr", {31'b0, disp_alc_ptr}, 32'd0);
      check_val("rst_dep_raw", {31'b0, dep_raw},      32'd0);
      check_val("rst_dep_waw", {31'b0, dep_waw},      32'd0);

      // Fill: rd=5 then rd=7
      tick();
      disp_alc_vld   = 1'b1;
      disp_alc_rdwen = 1'b1;
      disp_alc_rdidx = 5'd5;
      settle();
      check_val("alc0_ptr", {31'b0, disp_alc_ptr}, 32'd0);
      // Entry not yet visible in its allocate cycle.
      probe_raw("alc0_raw_not_yet", 5'd5, 1'b0);
      tick();
      disp_alc_rdidx = 5'd7;
      settle();
      check_val("alc1_ptr", {31'b0, disp_alc_ptr}, 32'd1);
      check_val("alc1_rdy", {31'b0, disp_alc_rdy}, 32'd1);
      tick();
      disp_alc_vld = 1'b0;
      settle();
      check_val("full_alc_rdy", {31'b0, disp_alc_rdy}, 32'd0);
      check_val("full_empty",   {31'b0, oitf_empty},   32'd0);
      check_val("full_lng_rdy", {31'b0, lng_wbck_rdy}, 32'd1);
      probe_raw("raw_rs1_7", 5'd7, 1'b1);
      probe_raw("raw_rs1_6", 5'd6, 1'b0);
      disp_rs2_en  = 1'b1;
      disp_rs2_idx = 5'd5;
      settle();
      check_val("raw_rs2_5", {31'b0, dep_raw}, 32'd1);
      disp_rs2_en  = 1'b0;
      disp_rd_en   = 1'b1;
      disp_rd_idx  = 5'd5;
      settle();
      check_val("waw_rd_5", {31'b0, dep_waw}, {31'b0, WawExp});
      disp_rd_idx  = 5'd6;
      settle();
      check_val("waw_rd_6", {31'b0, dep_waw}, 32'd0);
      disp_rd_en   = 1'b0;

      // Collision at full, with a refused allocate of rd=9
      tick();
      alu_wbck_vld   = 1'b1;
      alu_wbck_idx   = 5'd3;
      alu_wbck_data  = 32'hAAAA_0001;
      lng_wbck_vld   = 1'b1;
      lng_wbck_itag  = 1'b0;
      lng_wbck_data  = 32'h1234_5678;
      disp_alc_vld   = 1'b1;
      disp_alc_rdwen = 1'b1;
      disp_alc_rdidx = 5'd9;
      settle();
      check_val("col1_wen",     {31'b0, wbck_dest_wen}, 32'd1);
      check_val("col1_idx",     {27'b0, wbck_dest_idx}, 32'd5);
      check_val("col1_data",    wbck_dest_data,         32'h1234_5678);
      check_val("col1_alu_rdy", {31'b0, alu_wbck_rdy},  32'd0);
      check_val("col1_alc_rdy", {31'b0, disp_alc_rdy},  32'd0);
      // Retiring entry still flags in its retire cycle.
      probe_raw("col1_raw_5", 5'd5, 1'b1);
      tick();
      lng_wbck_vld = 1'b0;
      settle();
      check_val("col2_wen",     {31'b0, wbck_dest_wen}, 32'd1);
      check_val("col2_idx",     {27'b0, wbck_dest_idx}, 32'd3);
      check_val("col2_data",    wbck_dest_data,         32'hAAAA_0001);
      check_val("col2_alu_rdy", {31'b0, alu_wbck_rdy},  32'd1);
      check_val("col2_alc_rdy", {31'b0, disp_alc_rdy},  32'd1);
      check_val("col2_alc_ptr", {31'b0, disp_alc_ptr},  32'd0);
      probe_raw("col2_raw_5_clr", 5'd5, 1'b0);
      tick();
      alu_wbck_vld = 1'b0;
      disp_alc_vld = 1'b0;
      settle();
      // Wrap bit toggled: table reads full, not empty.
      check_val("wrap_alc_rdy", {31'b0, disp_alc_rdy}, 32'd0);
      check_val("wrap_empty",   {31'b0, oitf_empty},   32'd0);
      probe_raw("wrap_raw_9", 5'd9, 1'b1);

      // x0 ALU write
      alu_wbck_vld  = 1'b1;
      alu_wbck_idx  = 5'd0;
      alu_wbck_data = 32'hDEAD_BEEF;
      settle();
      check_val("x0_alu_rdy", {31'b0, alu_wbck_rdy},  32'd1);
      check_val("x0_alu_wen", {31'b0, wbck_dest_wen}, 32'd0);
      tick();
      alu_wbck_vld  = 1'b0;

      // Retire rd=7 to make room
      lng_wbck_vld  = 1'b1;
      lng_wbck_itag = 1'b1;
      lng_wbck_data = 32'h0000_0077;
      settle();
      check_val("ret7_wen", {31'b0, wbck_dest_wen}, 32'd1);
      check_val("ret7_idx", {27'b0, wbck_dest_idx}, 32'd7);
      tick();
      lng_wbck_vld = 1'b0;
      probe_raw("ret7_raw_clr", 5'd7, 1'b0);

      // Allocate rd=0
      disp_alc_vld   = 1'b1;
      disp_alc_rdwen = 1'b1;
      disp_alc_rdidx = 5'd0;
      settle();
      check_val("x0_alc_ptr", {31'b0, disp_alc_ptr}, 32'd1);
      tick();
      disp_alc_vld = 1'b0;
      probe_raw("x0_raw_0", 5'd0, 1'b0);
      probe_raw("x0_raw_9", 5'd9, 1'b1);

      // Asynchronous reset with two entries outstanding
      rst_n = 1'b0;
      settle();
      check_val("arst_empty_async", {31'b0, oitf_empty}, 32'd1);
      tick();
      rst_n = 1'b1;
      settle();
      check_val("arst_empty",   {31'b0, oitf_empty},   32'd1);
      check_val("arst_alc_rdy", {31'b0, disp_alc_rdy}, 32'd1);
      check_val("arst_alc_ptr", {31'b0, disp_alc_ptr}, 32'd0);
      check_val("arst_lng_rdy", {31'b0, lng_wbck_rdy}, 32'd0);
      probe_raw("arst_raw_9", 5'd9, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Safety net against a hang.
   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/rf_wbck_ctrl.md
# rf_wbck_ctrl

Write-back controller and scoreboard for the 32-entry integer regfile.
- Owns the regfile's single write port and shares it between the single-cycle ALU path and the long-pipe path (LSU/MULDIV).
- Keeps an in-order table of outstanding long-pipe instructions (OITF) so dispatch can detect RAW/WAW hazards against in-flight destinations.
- Sits between dispatch/execute and the regfile's `wbck_dest_*` port.

## Interface
- `OITF_DEPTH`, 2 — outstanding long-pipe entries; power of two, ≥2.
- `RFIDX_WIDTH`, 5 — register index width.
- `XLEN`, 32 — data width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `disp_alc_vld`  in  1  dispatch allocates an OITF entry for a long-pipe op.
- `disp_alc_rdy`  out  1  entry accepted; equals !full.
- `disp_alc_rdwen`  in  1  allocated op writes rd.
- `disp_alc_rdidx`  in  RFIDX_WIDTH  allocated op's rd.
- `disp_alc_ptr`  out  log2(OITF_DEPTH)  tag of the allocated entry (write pointer).
- `disp_rs1_en`, `disp_rs2_en`, `disp_rd_en`  in  1 each  operand/destination present for hazard check.
- `disp_rs1_idx`, `disp_rs2_idx`, `disp_rd_idx`  in  RFIDX_WIDTH each  indices checked.
- `dep_raw`  out  1  rs1 or rs2 matches a valid entry with rdwen=1.
- `dep_waw`  out  1  rd matches a valid entry with rdwen=1.
- `oitf_empty`  out  1  no outstanding entries.
- `alu_wbck_vld`  in  1  ALU write-back request.
- `alu_wbck_rdy`  out  1  ALU write-back accepted.
- `alu_wbck_idx`  in  RFIDX_WIDTH  ALU destination.
- `alu_wbck_data`  in  XLEN  ALU result.
- `lng_wbck_vld`  in  1  long-pipe completion for the head entry.
- `lng_wbck_rdy`  out  1  long-pipe completion accepted.
- `lng_wbck_itag`  in  log2(OITF_DEPTH)  tag of the completing op; must equal the read pointer.
- `lng_wbck_data`  in  XLEN  long-pipe result.
- `wbck_dest_wen`  out  1  regfile write enable.
- `wbck_dest_idx`  out  RFIDX_WIDTH  regfile write index.
- `wbck_dest_data`  out  XLEN  regfile write data.

## Operation
- **OITF storage:** circular buffer of {valid, rdwen, rdidx}. Write and read pointers each carry an extra wrap bit.
  - empty = pointers fully equal.
  - full = indices equal and wrap bits differ.
- **Allocate:** on `disp_alc_vld & disp_alc_rdy`, write the entry at wptr, set valid, wptr+1. Index wraps at OITF_DEPTH-1 → 0 and the wrap bit toggles.
- **Retire:** on `lng_wbck_vld & lng_wbck_rdy`, clear valid at rptr, rptr+1. `lng_wbck_rdy = !empty`. An itag mismatch is a protocol error; the block does not check it.
- **Arbitration:** fixed priority, long-pipe over ALU.
  - `alu_wbck_rdy = !(lng_wbck_vld & !empty)`.
  - Long-pipe selected: `wbck_dest_wen = head.rdwen & (head.rdidx != 0)`, `wbck_dest_idx = head.rdidx`, data = `lng_wbck_data`.
  - ALU selected: `wbck_dest_wen = alu_wbck_vld & (alu_wbck_idx != 0)`, with ALU index and data.
  - A write to x0 still completes the handshake but `wbck_dest_wen` stays 0.
- **Hazard check:** compare rs1/rs2/rd against all valid entries with rdwen=1. Each compare is gated by its `_en`; index 0 never matches.
- **Simultaneous allocate and retire:** both happen; count is unchanged. When full, allocation is refused even if a retire occurs in the same cycle (no fall-through).

## Timing
- **Reset values (rst_n low):** pointers 0, all valid bits 0, `oitf_empty=1`, `disp_alc_rdy=1`, `disp_alc_ptr=0`, `lng_wbck_rdy=0`, `dep_raw=dep_waw=0`. `alu_wbck_rdy` and `wbck_dest_*` follow their inputs; the bench holds all `_vld` low during reset.
- Reset asserted mid-operation discards every outstanding entry immediately and asynchronously.
- All ready, dep and `wbck_dest_*` outputs are combinational from inputs and current state. The regfile writes on the same clock edge as the handshake.
- An allocated entry is visible to the hazard check from the next cycle.
- A retiring entry still flags a hazard in its retire cycle, which is conservative. From the next cycle the regfile holds the new value and the flag is clear.
- ALU stall lasts exactly the cycles in which a valid long-pipe completion is presented.

## Configuration
- `RF_WBCK_WAW_CHK_EN` defined: `dep_waw` computed as above.
- `RF_WBCK_WAW_CHK_EN` undefined: `dep_waw` tied to 0 and the rd comparators are removed. Dispatch must then serialise long-pipe ops to the same rd by other means.

## Test plan
- **Reset:** release reset → `oitf_empty=1`, `disp_alc_rdy=1`, `lng_wbck_rdy=0`, `disp_alc_ptr=0`.
- **Fill:** allocate rd=5 then rd=7 with DEPTH=2.
  - After the 2nd allocate: `disp_alc_rdy=0`; `dep_raw=1` for rs1=7; `dep_raw=0` for rs1=6.
  - `dep_waw=1` for rd=5 with the macro defined, 0 without it.
- **Arbitration collision:** ALU (idx 3, 0xAAAA_0001) and long-pipe (head rd=5, 0x1234_5678) valid together.
  - Cycle 1: `wbck_dest_idx=5`, data 0x1234_5678, `alu_wbck_rdy=0`.
  - Cycle 2: `wbck_dest_idx=3`, data 0xAAAA_0001.
- **Full with simultaneous allocate/retire:** retire head while allocating rd=9 at full → allocate refused, count drops to 1. Next cycle the allocate is accepted with `disp_alc_ptr=0` (wrapped) and the wrap bit toggled.
- **x0 write:**
  - ALU write to idx 0 → handshake completes, `wbck_dest_wen=0`.
  - Allocate rd=0 then check rs1=0 → `dep_raw=0`.
- **Reset with entries outstanding:** assert rst_n low with 2 entries outstanding → next cycle `oitf_empty=1`, `dep_raw=0` for previously matching indices.
